// File: rtl/ioctl_uploader.sv
// ioctl_uploader: serves HPS ioctl upload reads for one ioctl_index from a
// byte-wide synchronous RAM. Byte 0 is prefetched when the session opens.
// A request that arrives while a fetch is still in flight is held in a
// one-deep pending slot. A further request while that slot is full is lost
// and raises the sticky overrun flag.
module ioctl_uploader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  INDEX  = 8'd4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [1:0] {IDLE, ARMED, FETCH, LATCH} state_t;

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nx;
  logic              session;
  logic              in_range;
  logic              pend_valid;
  logic              pend_oor;
  logic [ADDR_W-1:0] pend_addr;

  // Request serviced at this edge: the incoming one in ARMED, or in LATCH
  // the pending one (if any), otherwise the incoming one.
  logic              svc_valid;
  logic              svc_oor;
  logic [ADDR_W-1:0] svc_addr;

  assign session  = ioctl_upload && (ioctl_index == INDEX);
  assign in_range = (ioctl_addr >> ADDR_W) == 25'd0;
  assign ram_rd   = (state == FETCH);
  assign busy     = (state != IDLE);

  // Pick the request to be serviced at this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    svc_valid = 1'b0;
    svc_oor   = 1'b0;
    svc_addr  = ioctl_addr[ADDR_W-1:0];
    if (state == ARMED) begin
      svc_valid = ioctl_rd;
      svc_oor   = !in_range;
    end else if (state == LATCH) begin
      if (pend_valid) begin
        svc_valid = 1'b1;
        svc_oor   = pend_oor;
        svc_addr  = pend_addr;
      end else begin
        svc_valid = ioctl_rd;
        svc_oor   = !in_range;
      end
    end
  end

  // Next-state logic; losing the session aborts from any busy state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (session) state_nx = FETCH;
      ARMED:   if (!session) state_nx = IDLE;
               else if (svc_valid && !svc_oor) state_nx = FETCH;
      FETCH:   state_nx = session ? LATCH : IDLE;
      LATCH:   if (!session) state_nx = IDLE;
               else if (svc_valid && !svc_oor) state_nx = FETCH;
               else state_nx = ARMED;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Datapath registers: returned byte, wait, RAM address, pending slot, status.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      ram_addr   <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      byte_count <= '0;
      pend_valid <= 1'b0;
      pend_oor   <= 1'b0;
      pend_addr  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (session) begin
          ram_addr   <= '0;
          byte_count <= '0;
          overrun    <= 1'b0;
          ioctl_wait <= 1'b0;
          pend_valid <= 1'b0;
        end
      end else if (!session) begin
        ioctl_wait <= 1'b0;
        pend_valid <= 1'b0;
        done       <= 1'b1;
      end else begin
        if (state == LATCH) begin
          ioctl_din  <= ram_dout;
          ioctl_wait <= 1'b0;
          pend_valid <= 1'b0;
        end
        // Launch (or answer with 8'hFF) the request serviced at this edge.
        // A pending out-of-range request answers straight away, so it
        // replaces the byte just latched.
        if ((state == ARMED || state == LATCH) && svc_valid) begin
          if (byte_count != COUNT_MAX) byte_count <= byte_count + 1'b1;
          if (svc_oor) begin
            ioctl_din <= 8'hFF;
          end else begin
            ram_addr   <= svc_addr;
            ioctl_wait <= 1'b1;
          end
        end
        // Requests that arrive while a fetch is in flight go to the slot.
        // In LATCH an empty slot means the incoming request was serviced above.
        if ((state == FETCH || state == LATCH) && ioctl_rd) begin
          if (pend_valid) begin
            overrun <= 1'b1;
          end else if (state == FETCH) begin
            pend_valid <= 1'b1;
            pend_oor   <= !in_range;
            pend_addr  <= ioctl_addr[ADDR_W-1:0];
            ioctl_wait <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ioctl_uploader.sv
// Self-checking bench for ioctl_uploader: a behavioural RAM, hand-written
// timing sequences, a table of read vectors and a queue of expected bytes.
module tb_ioctl_uploader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_dout;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [8:0]  byte_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] expect_q [$];
  int         exp_count;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [5];

  ioctl_uploader #(.ADDR_W(8), .INDEX(8'd4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_dout     (ram_dout),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .byte_count   (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous RAM: data one edge after the read strobe.
  always @(posedge clk_sys) if (ram_rd) ram_dout <= mem[ram_addr];

  function automatic logic [7:0] model_byte(input logic [24:0] a);
    logic [7:0] r;
    if (a < 25'd256) r = mem[a[7:0]];
    else             r = 8'hFF;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    if (expect_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'(expect_q.size()), 32'd1);
    end else begin
      e = expect_q.pop_front();
      check(name, 32'(ioctl_din), 32'(e));
    end
  endtask

  // One ioctl_rd pulse, then wait (bounded) for the byte.
  task automatic do_read(input logic [24:0] a, input string name);
    int n;
    expect_q.push_back(model_byte(a));
    exp_count++;
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin
      tick();
      n++;
    end
    check({name, "_wait"}, 32'(ioctl_wait), 32'd0);
    pop_check(name);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_din"},   32'(ioctl_din),  32'h0);
    check({tag, "_wait"},  32'(ioctl_wait), 32'h0);
    check({tag, "_raddr"}, 32'(ram_addr),   32'h0);
    check({tag, "_ramrd"}, 32'(ram_rd),     32'h0);
    check({tag, "_busy"},  32'(busy),       32'h0);
    check({tag, "_done"},  32'(done),       32'h0);
    check({tag, "_ovr"},   32'(overrun),    32'h0);
    check({tag, "_count"}, 32'(byte_count), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h00] = 8'h5A;
    mem[8'h10] = 8'hC3;
    vecs[0] = '{25'h0000000, model_byte(25'h0000000)};
    vecs[1] = '{25'h00000FF, model_byte(25'h00000FF)};
    vecs[2] = '{25'h0000080, model_byte(25'h0000080)};
    vecs[3] = '{25'h1FFFFFF, 8'hFF};
    vecs[4] = '{25'h0000042, model_byte(25'h0000042)};
    exp_count = 0;

    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0;
    tick(); tick();
    check_reset_values("reset");

    // Session start: prefetch of byte 0, not counted.
    reset = 1'b0; ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick();
    check("start_ramrd", 32'(ram_rd), 32'd1);
    check("start_raddr", 32'(ram_addr), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    tick();
    check("start_ramrd_off", 32'(ram_rd), 32'd0);
    tick();
    check("start_din", 32'(ioctl_din), 32'h5A);
    check("start_wait", 32'(ioctl_wait), 32'd0);
    check("start_count", 32'(byte_count), 32'd0);

    // Single in-range read with exact latency.
    ioctl_rd = 1'b1; ioctl_addr = 25'h10;
    tick();
    ioctl_rd = 1'b0; exp_count++;
    check("rd_wait_n", 32'(ioctl_wait), 32'd1);
    check("rd_raddr", 32'(ram_addr), 32'h10);
    tick();
    check("rd_wait_n1", 32'(ioctl_wait), 32'd1);
    tick();
    check("rd_din_n2", 32'(ioctl_din), 32'hC3);
    check("rd_wait_n2", 32'(ioctl_wait), 32'd0);
    check("rd_count", 32'(byte_count), 32'd1);

    // Out-of-range read: 8'hFF next edge, no RAM access, no wait.
    ioctl_rd = 1'b1; ioctl_addr = 25'h100;
    tick();
    ioctl_rd = 1'b0; exp_count++;
    check("oor_din", 32'(ioctl_din), 32'hFF);
    check("oor_wait", 32'(ioctl_wait), 32'd0);
    check("oor_ramrd", 32'(ram_rd), 32'd0);
    tick();
    check("oor_ramrd2", 32'(ram_rd), 32'd0);
    check("oor_count", 32'(byte_count), 32'd2);

    // Table-driven reads through the scoreboard.
    foreach (vecs[i]) begin
      expect_q.push_back(vecs[i].exp);
      void'(expect_q.pop_back());
      do_read(vecs[i].addr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_exp", i), 32'(ioctl_din), 32'(vecs[i].exp));
    end
    check("vec_count", 32'(byte_count), 32'(exp_count));

    // Back-to-back: request, pending request in FETCH, lost one in LATCH.
    expect_q.push_back(mem[8'h20]);
    expect_q.push_back(mem[8'h21]);
    ioctl_rd = 1'b1; ioctl_addr = 25'h20;
    tick();
    ioctl_addr = 25'h21;
    tick();
    check("b2b_pend_wait", 32'(ioctl_wait), 32'd1);
    ioctl_addr = 25'h22;
    tick();
    ioctl_rd = 1'b0; exp_count += 2;
    pop_check("b2b_first");
    check("b2b_wait_mid", 32'(ioctl_wait), 32'd1);
    check("b2b_overrun", 32'(overrun), 32'd1);
    check("b2b_raddr", 32'(ram_addr), 32'h21);
    tick(); tick();
    pop_check("b2b_second");
    check("b2b_wait_end", 32'(ioctl_wait), 32'd0);
    check("b2b_count", 32'(byte_count), 32'(exp_count));

    // Abort: upload drops during FETCH.
    ioctl_rd = 1'b1; ioctl_addr = 25'h30;
    tick();
    ioctl_rd = 1'b0; ioctl_upload = 1'b0; exp_count++;
    check("abort_in_fetch", 32'(ram_rd), 32'd1);
    tick();
    check("abort_done", 32'(done), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wait", 32'(ioctl_wait), 32'd0);
    check("abort_ramrd", 32'(ram_rd), 32'd0);
    check("abort_din_hold", 32'(ioctl_din), 32'(mem[8'h21]));
    check("abort_count_hold", 32'(byte_count), 32'(exp_count));
    tick();
    check("abort_done_pulse", 32'(done), 32'd0);

    // Foreign index: no activity, and reads in IDLE are ignored.
    ioctl_upload = 1'b1; ioctl_index = 8'd3;
    ioctl_rd = 1'b1; ioctl_addr = 25'h05;
    tick();
    ioctl_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idx3_busy%0d", i), 32'(busy), 32'd0);
      check($sformatf("idx3_ramrd%0d", i), 32'(ram_rd), 32'd0);
      tick();
    end
    check("idx3_count", 32'(byte_count), 32'(exp_count));
    check("idx3_din", 32'(ioctl_din), 32'(mem[8'h21]));

    // New session clears status, then reset lands in LATCH.
    ioctl_index = 8'd4;
    tick();
    check("restart_ovr", 32'(overrun), 32'd0);
    check("restart_count", 32'(byte_count), 32'd0);
    tick();
    check("restart_latch", 32'(ram_rd), 32'd0);
    reset = 1'b1;
    tick();
    check_reset_values("rst_latch");
    tick();
    check("rst_no_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
